mem_dbridge: RTL and testbench

MEM_DBRIDGE -- requirements
Module: mem_dbridge

---
 rtl/mem_dbridge_if.sv | 46 ++++
 rtl/mem_dbridge.sv | 219 +++++++++++++++++++++
 tb/tb_mem_dbridge.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dbridge_if.sv
// Core-side and memory-side bundles for the data bridge.
// dmem_if: master = core, slave = bridge. mem_if: master = bridge, slave = memory.
interface dmem_if #(
   parameter int XLEN = 32
);
   logic            dmem_req;
   logic            dmem_ready;
   logic            dmem_cmd;
   logic [1:0]      dmem_width;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic [XLEN-1:0] dmem_rdata;
   logic            dmem_resp;
   logic            dmem_err;

   modport master (
      output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
      input  dmem_ready, dmem_rdata, dmem_resp, dmem_err
   );
   modport slave (
      input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
      output dmem_ready, dmem_rdata, dmem_resp, dmem_err
   );
endinterface

interface mem_if #(
   parameter int XLEN = 32
);
   logic            mem_req;
   logic            mem_req_ack;
   logic            mem_cmd;
   logic [1:0]      mem_width;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_wdata;
   logic [XLEN-1:0] mem_rdata;
   logic [1:0]      mem_resp;

   modport master (
      output mem_req, mem_cmd, mem_width, mem_addr, mem_wdata,
      input  mem_req_ack, mem_rdata, mem_resp
   );
   modport slave (
      input  mem_req, mem_cmd, mem_width, mem_addr, mem_wdata,
      output mem_req_ack, mem_rdata, mem_resp
   );
endinterface

// File: rtl/mem_dbridge.sv
// Data-memory bridge: queues core loads/stores, issues one downstream
// transaction at a time, returns in-order responses and counts completions.
// Ports: clk, rst_n (sync, active low); dmem (core side, slave);
// mem (downstream side, master); cnt_rd/cnt_wr/cnt_err saturating counters.
module mem_dbridge #(
   parameter int XLEN       = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   dmem_if.slave       dmem,
   mem_if.master       mem,
   output logic [31:0] cnt_rd,
   output logic [31:0] cnt_wr,
   output logic [31:0] cnt_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   typedef struct packed {
      logic            cmd;
      logic [1:0]      width;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } state_t;

   entry_t fifo_q [FIFO_DEPTH];
   entry_t fifo_d [FIFO_DEPTH];

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   state_t      state_q, state_d;

   logic            mem_req_q, mem_req_d;
   logic            mem_cmd_q, mem_cmd_d;
   logic [1:0]      mem_width_q, mem_width_d;
   logic [XLEN-1:0] mem_addr_q, mem_addr_d;
   logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;

   logic            dmem_resp_q, dmem_resp_d;
   logic            dmem_err_q, dmem_err_d;
   logic [XLEN-1:0] dmem_rdata_q, dmem_rdata_d;

   logic [31:0] cnt_rd_q, cnt_rd_d;
   logic [31:0] cnt_wr_q, cnt_wr_d;
   logic [31:0] cnt_err_q, cnt_err_d;

   logic   full;
   logic   empty;
   logic   push;
   logic   head_ok;
   logic   done;
   logic   done_err;
   entry_t head;

   function automatic logic [31:0] sat_inc(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
   endfunction

   // Extra pointer bit separates full (MSBs differ) from empty.
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign push  = dmem.dmem_req & ~full;
   assign head  = fifo_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      head_ok = 1'b0;
      unique case (head.width)
         2'b00:   head_ok = 1'b1;
         2'b01:   head_ok = ~head.addr[0];
         2'b10:   head_ok = (head.addr[1:0] == 2'b00);
         default: head_ok = 1'b0;
      endcase
   end

   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      if (push) begin
         fifo_d[wr_ptr_q[AW-1:0]] = '{
            cmd:   dmem.dmem_cmd,
            width: dmem.dmem_width,
            addr:  dmem.dmem_addr,
            wdata: dmem.dmem_wdata
         };
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
   end

   always_comb begin
      state_d      = state_q;
      rd_ptr_d     = rd_ptr_q;
      mem_req_d    = mem_req_q;
      mem_cmd_d    = mem_cmd_q;
      mem_width_d  = mem_width_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      dmem_resp_d  = 1'b0;
      dmem_err_d   = 1'b0;
      dmem_rdata_d = '0;
      cnt_rd_d     = cnt_rd_q;
      cnt_wr_d     = cnt_wr_q;
      cnt_err_d    = cnt_err_q;
      done         = 1'b0;
      done_err     = (mem.mem_resp != 2'b01);

      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               rd_ptr_d = rd_ptr_q + PTR_ONE;
               if (head_ok) begin
                  mem_req_d   = 1'b1;
                  mem_cmd_d   = head.cmd;
                  mem_width_d = head.width;
                  mem_addr_d  = head.addr;
                  mem_wdata_d = head.wdata;
                  state_d     = REQ;
               end else begin
                  // Misaligned: answered locally, never reaches memory.
                  dmem_resp_d = 1'b1;
                  dmem_err_d  = 1'b1;
                  cnt_err_d   = sat_inc(cnt_err_q);
               end
            end
         end
         REQ: begin
            if (mem.mem_req_ack) begin
               mem_req_d = 1'b0;
               if (mem.mem_resp != 2'b00) begin
                  done = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (mem.mem_resp != 2'b00) begin
               done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (done) begin
         state_d     = IDLE;
         dmem_resp_d = 1'b1;
         dmem_err_d  = done_err;
         if (done_err) begin
            cnt_err_d = sat_inc(cnt_err_q);
         end else if (mem_cmd_q) begin
            cnt_wr_d = sat_inc(cnt_wr_q);
         end else begin
            cnt_rd_d     = sat_inc(cnt_rd_q);
            dmem_rdata_d = mem.mem_rdata;
         end
      end
   end

   // Queue payload needs no reset; pointers define validity.
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         state_q      <= IDLE;
         mem_req_q    <= 1'b0;
         mem_cmd_q    <= 1'b0;
         mem_width_q  <= 2'b00;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         dmem_resp_q  <= 1'b0;
         dmem_err_q   <= 1'b0;
         dmem_rdata_q <= '0;
         cnt_rd_q     <= '0;
         cnt_wr_q     <= '0;
         cnt_err_q    <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         state_q      <= state_d;
         mem_req_q    <= mem_req_d;
         mem_cmd_q    <= mem_cmd_d;
         mem_width_q  <= mem_width_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         dmem_resp_q  <= dmem_resp_d;
         dmem_err_q   <= dmem_err_d;
         dmem_rdata_q <= dmem_rdata_d;
         cnt_rd_q     <= cnt_rd_d;
         cnt_wr_q     <= cnt_wr_d;
         cnt_err_q    <= cnt_err_d;
      end
   end

   assign dmem.dmem_ready = ~full;
   assign dmem.dmem_resp  = dmem_resp_q;
   assign dmem.dmem_err   = dmem_err_q;
   assign dmem.dmem_rdata = dmem_rdata_q;
   assign mem.mem_req     = mem_req_q;
   assign mem.mem_cmd     = mem_cmd_q;
   assign mem.mem_width   = mem_width_q;
   assign mem.mem_addr    = mem_addr_q;
   assign mem.mem_wdata   = mem_wdata_q;
   assign cnt_rd          = cnt_rd_q;
   assign cnt_wr          = cnt_wr_q;
   assign cnt_err         = cnt_err_q;

endmodule

// File: tb/tb_mem_dbridge.sv
// Testbench for mem_dbridge: directed scenarios plus randomized traffic
// against a transaction-level model of ordering, errors and counters.
module tb_mem_dbridge;

   logic        clk;
   logic        rst_n;
   logic [31:0] cnt_rd;
   logic [31:0] cnt_wr;
   logic [31:0] cnt_err;

   dmem_if #(.XLEN(32)) dif ();
   mem_if  #(.XLEN(32)) mif ();

   mem_dbridge #(.XLEN(32), .FIFO_DEPTH(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .dmem    (dif),
      .mem     (mif),
      .cnt_rd  (cnt_rd),
      .cnt_wr  (cnt_wr),
      .cnt_err (cnt_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        cmd;
      bit [1:0]  width;
      bit [31:0] addr;
      bit [31:0] wdata;
   } req_t;

   typedef struct {
      bit [1:0]  code;
      bit [31:0] rdata;
      bit [31:0] addr;
   } out_t;

   localparam bit [31:0] K = 32'hA5A5_0000;

   int n_chk;
   int n_err;

   req_t push_q  [$];
   req_t legal_q [$];
   out_t out_q   [$];
   bit [31:0] got_q [$];

   bit [31:0] m_rd;
   bit [31:0] m_wr;
   bit [31:0] m_err;

   bit   outstanding;
   int   wait_n;
   req_t cur;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit is_legal(input bit [1:0] w, input bit [31:0] a);
      if (w == 2'd0) return 1'b1;
      if (w == 2'd1) return (a % 2) == 0;
      if (w == 2'd2) return (a % 4) == 0;
      return 1'b0;
   endfunction

   function automatic bit [31:0] inc(input bit [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 1;
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   task automatic drive_req(input bit c, input bit [1:0] w,
                            input bit [31:0] a, input bit [31:0] d);
      dif.dmem_req   = 1'b1;
      dif.dmem_cmd   = c;
      dif.dmem_width = w;
      dif.dmem_addr  = a;
      dif.dmem_wdata = d;
   endtask

   task automatic idle_core();
      dif.dmem_req = 1'b0;
   endtask

   task automatic observe();
      req_t p;
      out_t o;
      bit   e_err;
      bit [31:0] e_rd;
      if (dif.dmem_resp) begin
         if (push_q.size() == 0) begin
            check("resp_unexpected", 1, 0);
         end else begin
            p = push_q.pop_front();
            e_err = 1'b1;
            e_rd  = 0;
            if (!is_legal(p.width, p.addr)) begin
               m_err = inc(m_err);
            end else if (out_q.size() == 0) begin
               check("resp_no_outcome", 1, 0);
            end else begin
               o = out_q.pop_front();
               check("resp_order", o.addr, p.addr);
               e_err = (o.code != 2'd1);
               if (e_err) m_err = inc(m_err);
               else if (p.cmd) m_wr = inc(m_wr);
               else begin
                  m_rd = inc(m_rd);
                  e_rd = o.rdata;
               end
            end
            check("resp_err", dif.dmem_err, e_err);
            check("resp_rdata", dif.dmem_rdata, e_rd);
         end
      end
      check("cnt_rd", cnt_rd, m_rd);
      check("cnt_wr", cnt_wr, m_wr);
      check("cnt_err", cnt_err, m_err);
   endtask

   task automatic give();
      int r;
      out_t o;
      r = $urandom_range(0, 9);
      o.code  = (r < 7) ? 2'd1 : ((r < 9) ? 2'd2 : 2'd3);
      o.rdata = $urandom;
      o.addr  = cur.addr;
      mif.mem_resp  = o.code;
      mif.mem_rdata = o.rdata;
      out_q.push_back(o);
   endtask

   task automatic mem_step();
      if (!outstanding) begin
         if (mif.mem_req) begin
            mif.mem_resp = 2'd0;
            mif.mem_req_ack = 1'b0;
            if (legal_q.size() == 0) begin
               check("memreq_unexpected", 1, 0);
            end else begin
               cur = legal_q[0];
               check("mem_addr", mif.mem_addr, cur.addr);
               check("mem_cmd", mif.mem_cmd, cur.cmd);
               check("mem_width", mif.mem_width, cur.width);
               check("mem_wdata", mif.mem_wdata, cur.wdata);
               if ($urandom_range(0, 2) != 0) begin
                  mif.mem_req_ack = 1'b1;
                  void'(legal_q.pop_front());
                  wait_n = $urandom_range(0, 3);
                  if (wait_n == 0) give();
                  else outstanding = 1'b1;
               end
            end
         end else begin
            // Noise while idle must be ignored.
            mif.mem_req_ack = 1'($urandom_range(0, 1));
            mif.mem_resp    = 2'($urandom_range(0, 3));
            mif.mem_rdata   = $urandom;
         end
      end else begin
         mif.mem_req_ack = 1'b0;
         mif.mem_resp    = 2'd0;
         wait_n--;
         if (wait_n == 0) begin
            give();
            outstanding = 1'b0;
         end
      end
   endtask

   task automatic core_step();
      int   r;
      req_t q;
      if ($urandom_range(0, 1) == 1) begin
         r = $urandom_range(0, 9);
         q.cmd   = 1'($urandom_range(0, 1));
         q.width = (r == 9) ? 2'd3 : 2'(r % 3);
         q.addr  = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 4) == 0) q.addr = q.addr | 32'($urandom_range(1, 3));
         q.wdata = $urandom;
         drive_req(q.cmd, q.width, q.addr, q.wdata);
         if (dif.dmem_ready) begin
            push_q.push_back(q);
            if (is_legal(q.width, q.addr)) legal_q.push_back(q);
         end
      end else begin
         idle_core();
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      clk = 1'b0;
      rst_n = 1'b0;
      n_chk = 0;
      n_err = 0;
      dif.dmem_req = 1'b0;
      dif.dmem_cmd = 1'b0;
      dif.dmem_width = 2'd0;
      dif.dmem_addr = '0;
      dif.dmem_wdata = '0;
      mif.mem_req_ack = 1'b0;
      mif.mem_resp = 2'd0;
      mif.mem_rdata = '0;
      repeat (2) step();
      rst_n = 1'b1;
      step();

      check("rst_ready", dif.dmem_ready, 1);
      check("rst_mem_req", mif.mem_req, 0);
      check("rst_resp", dif.dmem_resp, 0);
      check("rst_err", dif.dmem_err, 0);
      check("rst_rdata", dif.dmem_rdata, 0);
      check("rst_mem_addr", mif.mem_addr, 0);
      check("rst_cnt_rd", cnt_rd, 0);
      check("rst_cnt_err", cnt_err, 0);

      // Word read, zero-wait memory.
      drive_req(1'b0, 2'd2, 32'h100, 32'h0);
      step();
      check("rd_mreq_early", mif.mem_req, 0);
      idle_core();
      step();
      check("rd_mreq", mif.mem_req, 1);
      check("rd_maddr", mif.mem_addr, 32'h100);
      check("rd_mwidth", mif.mem_width, 2);
      check("rd_mcmd", mif.mem_cmd, 0);
      mif.mem_req_ack = 1'b1;
      mif.mem_resp = 2'd1;
      mif.mem_rdata = 32'hDEAD_BEEF;
      step();
      check("rd_resp", dif.dmem_resp, 1);
      check("rd_rdata", dif.dmem_rdata, 32'hDEAD_BEEF);
      check("rd_err", dif.dmem_err, 0);
      check("rd_mreq_drop", mif.mem_req, 0);
      check("rd_cnt", cnt_rd, 1);
      mif.mem_req_ack = 1'b0;
      mif.mem_resp = 2'd0;
      step();
      check("rd_pulse", dif.dmem_resp, 0);

      // Misaligned half write.
      drive_req(1'b1, 2'd1, 32'h101, 32'hAAAA);
      step();
      check("mis_resp_early", dif.dmem_resp, 0);
      idle_core();
      step();
      check("mis_resp", dif.dmem_resp, 1);
      check("mis_err", dif.dmem_err, 1);
      check("mis_rdata", dif.dmem_rdata, 0);
      check("mis_cnt_err", cnt_err, 1);
      check("mis_cnt_wr", cnt_wr, 0);
      step();
      check("mis_no_mreq", mif.mem_req, 0);

      // Read answered with error after waiting.
      drive_req(1'b0, 2'd2, 32'h200, 32'h0);
      step();
      idle_core();
      step();
      check("er_mreq", mif.mem_req, 1);
      mif.mem_req_ack = 1'b1;
      mif.mem_resp = 2'd0;
      step();
      check("er_mreq_drop", mif.mem_req, 0);
      mif.mem_req_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("er_wait", dif.dmem_resp, 0);
      end
      mif.mem_resp = 2'd2;
      mif.mem_rdata = 32'h1234_5678;
      step();
      check("er_resp", dif.dmem_resp, 1);
      check("er_err", dif.dmem_err, 1);
      check("er_rdata", dif.dmem_rdata, 0);
      check("er_cnt_err", cnt_err, 2);
      check("er_cnt_rd", cnt_rd, 1);
      mif.mem_resp = 2'd0;
      step();

      // Fill the queue while memory stalls; one in flight plus two queued.
      drive_req(1'b0, 2'd2, 32'h300, 32'h0);
      step();
      check("fill_rdy0", dif.dmem_ready, 1);
      drive_req(1'b0, 2'd2, 32'h304, 32'h0);
      step();
      check("fill_rdy1", dif.dmem_ready, 1);
      check("fill_maddr0", mif.mem_addr, 32'h300);
      drive_req(1'b0, 2'd2, 32'h308, 32'h0);
      step();
      check("fill_full", dif.dmem_ready, 0);
      check("fill_maddr1", mif.mem_addr, 32'h300);
      drive_req(1'b0, 2'd2, 32'h30C, 32'h0);
      step();
      check("fill_full2", dif.dmem_ready, 0);
      check("fill_hold", mif.mem_addr, 32'h300);
      check("fill_hold_req", mif.mem_req, 1);
      idle_core();
      mif.mem_req_ack = 1'b1;
      mif.mem_resp = 2'd1;
      mif.mem_rdata = mif.mem_addr ^ K;
      got_q.delete();
      for (int i = 0; i < 20; i++) begin
         step();
         if (dif.dmem_resp) got_q.push_back(dif.dmem_rdata);
         mif.mem_rdata = mif.mem_addr ^ K;
      end
      check("fill_nresp", got_q.size(), 3);
      for (int i = 0; i < got_q.size() && i < 3; i++) begin
         check("fill_order", got_q[i], (32'h300 + 32'(4 * i)) ^ K);
      end
      mif.mem_req_ack = 1'b0;
      mif.mem_resp = 2'd0;
      check("fill_rdy_end", dif.dmem_ready, 1);

      // Reset while waiting; a late answer must be ignored.
      drive_req(1'b0, 2'd2, 32'h400, 32'h0);
      step();
      idle_core();
      step();
      check("rw_mreq", mif.mem_req, 1);
      mif.mem_req_ack = 1'b1;
      step();
      mif.mem_req_ack = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      mif.mem_resp = 2'd1;
      mif.mem_rdata = 32'hCAFE_F00D;
      for (int i = 0; i < 4; i++) begin
         step();
         check("rw_no_resp", dif.dmem_resp, 0);
         mif.mem_resp = 2'd0;
      end
      check("rw_cnt_rd", cnt_rd, 0);
      check("rw_cnt_err", cnt_err, 0);
      check("rw_cnt_wr", cnt_wr, 0);
      check("rw_ready", dif.dmem_ready, 1);
      check("rw_mreq", mif.mem_req, 0);

      // Write counter saturation.
      force dut.cnt_wr_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_wr_q;
      check("sat_pre", cnt_wr, 32'hFFFF_FFFF);
      drive_req(1'b1, 2'd2, 32'h500, 32'h55);
      step();
      idle_core();
      step();
      check("sat_mcmd", mif.mem_cmd, 1);
      check("sat_mwdata", mif.mem_wdata, 32'h55);
      mif.mem_req_ack = 1'b1;
      mif.mem_resp = 2'd1;
      step();
      check("sat_resp", dif.dmem_resp, 1);
      check("sat_err", dif.dmem_err, 0);
      check("sat_cnt_wr", cnt_wr, 32'hFFFF_FFFF);
      mif.mem_req_ack = 1'b0;
      mif.mem_resp = 2'd0;

      // Randomized traffic.
      do_reset();
      m_rd = 0;
      m_wr = 0;
      m_err = 0;
      outstanding = 1'b0;
      push_q.delete();
      legal_q.delete();
      out_q.delete();
      for (int c = 0; c < 800; c++) begin
         observe();
         mem_step();
         core_step();
         step();
      end
      idle_core();
      for (int c = 0; c < 300; c++) begin
         observe();
         if (push_q.size() == 0 && !outstanding) break;
         mem_step();
         step();
      end
      check("drain", push_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
